// File: rtl/fulladder_pkg.sv
// Shared definitions for the ripple-carry adder: the widest legal operand
// width and the result record used by the adder core.
package fulladder_pkg;

   localparam int FA_MAX_WIDTH = 64;

   // Sum is carried at the maximum width so one record type serves every
   // instance width; bits above the active width are always zero.
   typedef struct packed {
      logic [FA_MAX_WIDTH-1:0] s;
      logic                    co;
      logic                    ovf;
   } fa_result_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell: the building block of the ripple carry chain.
// Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with registered outputs, one cycle of
// latency. The carry chain is built from fa_cell instances; overflow is the
// XOR of the carries into and out of the MSB cell.
// Optional macro FULLADDER_CIN_EN adds the in_ci carry-in port; without it
// the carry into cell 0 is tied to zero.
module full_adder
   import fulladder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef FULLADDER_CIN_EN
   input  logic             in_ci,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out_s,
   output logic             out_co,
   output logic             out_ovf
);

   logic             ci;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   fa_result_t       core_p0;

   logic [WIDTH-1:0] s_p1;
   logic             co_p1;
   logic             ovf_p1;
   logic             vld_p1;

`ifdef FULLADDER_CIN_EN
   assign ci = in_ci;
`else
   assign ci = 1'b0;
`endif

   assign carry[0] = ci;

   // ---- stage p0: combinational ripple chain ----
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (in_a[i]),
         .b  (in_b[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   // Pack the chain result into the shared record, zero above WIDTH.
   always_comb begin
      core_p0                = '0;
      core_p0.s[WIDTH-1:0]   = sum;
      core_p0.co             = carry[WIDTH];
      core_p0.ovf            = carry[WIDTH] ^ carry[WIDTH-1];
   end

   // Upper record bits are constant zero; fold them away explicitly.
   if (WIDTH < FA_MAX_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^core_p0.s[FA_MAX_WIDTH-1:WIDTH];
   end

   // ---- stage p1: output registers ----
   // Load the result on a valid beat, hold it otherwise; reset clears all.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         s_p1   <= '0;
         co_p1  <= 1'b0;
         ovf_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            s_p1   <= core_p0.s[WIDTH-1:0];
            co_p1  <= core_p0.co;
            ovf_p1 <= core_p0.ovf;
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_s     = s_p1;
   assign out_co    = co_p1;
   assign out_ovf   = ovf_p1;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=8 instance share
// clock, reset and in_valid; a WIDTH=4 instance is added with FULLADDER_CIN_EN.
module tb_full_adder;

   logic       clk;
   logic       rst;
   logic       valid;

   logic [0:0] a1, b1, s1;
   logic       co1, ovf1, vld1;

   logic [7:0] a8, b8, s8;
   logic       co8, ovf8, vld8;

`ifdef FULLADDER_CIN_EN
   logic [3:0] a4, b4, s4;
   logic       ci4, co4, ovf4, vld4;
   logic       ci_zero;
`endif

   int errors;
   int checks;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
      logic       co;
      logic       ovf;
   } vec_t;

   // Hand-computed WIDTH=8 vectors, applied back-to-back.
   vec_t vecs [8] = '{
      '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
      '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
      '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1},
      '{8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0},
      '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0},
      '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
      '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0},
      '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0}
   };

   // WIDTH=1 expected {co,s} for {b,a} = 0,1,2,3.
   logic [1:0] exp1 [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

   full_adder #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid),
      .in_a      (a1),
      .in_b      (b1),
`ifdef FULLADDER_CIN_EN
      .in_ci     (ci_zero),
`endif
      .out_valid (vld1),
      .out_s     (s1),
      .out_co    (co1),
      .out_ovf   (ovf1)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid),
      .in_a      (a8),
      .in_b      (b8),
`ifdef FULLADDER_CIN_EN
      .in_ci     (ci_zero),
`endif
      .out_valid (vld8),
      .out_s     (s8),
      .out_co    (co8),
      .out_ovf   (ovf8)
   );

`ifdef FULLADDER_CIN_EN
   full_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid),
      .in_a      (a4),
      .in_b      (b4),
      .in_ci     (ci4),
      .out_valid (vld4),
      .out_s     (s4),
      .out_co    (co4),
      .out_ovf   (ovf4)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      valid  = 1'b1;
      a1 = 1'b1;  b1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF;
`ifdef FULLADDER_CIN_EN
      ci_zero = 1'b0;
      a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
`endif

      // Reset wins over in_valid with all-ones operands, two edges.
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("rst_s8",   s8,   8'h00);
         chk("rst_co8",  co8,  1'b0);
         chk("rst_ovf8", ovf8, 1'b0);
         chk("rst_vld8", vld8, 1'b0);
         chk("rst_s1",   s1,   1'b0);
         chk("rst_co1",  co1,  1'b0);
         chk("rst_vld1", vld1, 1'b0);
      end
      rst = 1'b0;

      // WIDTH=1 exhaustive truth table on consecutive cycles.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         a1 = ab[0];
         b1 = ab[1];
         tick();
         chk("w1_cos",  {co1, s1}, exp1[i]);
         chk("w1_ovf",  ovf1, exp1[i][1]);
         chk("w1_vld",  vld1, 1'b1);
      end

      // WIDTH=8 back-to-back directed vectors, one result per cycle.
      for (int i = 0; i < 8; i++) begin
         a8 = vecs[i].a;
         b8 = vecs[i].b;
         tick();
         chk("w8_s",   s8,   vecs[i].s);
         chk("w8_co",  co8,  vecs[i].co);
         chk("w8_ovf", ovf8, vecs[i].ovf);
         chk("w8_vld", vld8, 1'b1);
      end

      // Hold: result 8'h46 stays while in_valid=0, even with X operands.
      valid = 1'b0;
      a8 = 'x; b8 = 'x; a1 = 'x; b1 = 'x;
      tick();
      chk("hold_s8x",  s8,   8'h46);
      chk("hold_co8x", co8,  1'b0);
      chk("hold_ov8x", ovf8, 1'b0);
      chk("hold_vld8", vld8, 1'b0);
      chk("hold_vld1", vld1, 1'b0);
      a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
      tick();
      chk("hold_s8",   s8,   8'h46);

      // Reset pulse between edges has no effect.
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #2;
      chk("glitch_s8",   s8, 8'h46);
      tick();
      chk("glitch_s8b",  s8, 8'h46);

      // Reset pulse mid-stream with in_valid held high.
      valid = 1'b1;
      a8 = 8'h01; b8 = 8'h02;
      tick();
      chk("mid_s8a",  s8,   8'h03);
      chk("mid_vlda", vld8, 1'b1);
      rst = 1'b1;
      a8 = 8'h10; b8 = 8'h20;
      tick();
      chk("mid_rst_s8",   s8,   8'h00);
      chk("mid_rst_co8",  co8,  1'b0);
      chk("mid_rst_ovf8", ovf8, 1'b0);
      chk("mid_rst_vld8", vld8, 1'b0);
      rst = 1'b0;
      a8 = 8'hF0; b8 = 8'h20;
      tick();
      chk("mid_s8b",   s8,   8'h10);
      chk("mid_co8b",  co8,  1'b1);
      chk("mid_ovf8b", ovf8, 1'b0);
      chk("mid_vldb",  vld8, 1'b1);

`ifdef FULLADDER_CIN_EN
      // Carry-in: F + 0 + 1 wraps, F + 0 + 0 does not.
      a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
      tick();
      chk("cin1_s4",   s4,   4'h0);
      chk("cin1_co4",  co4,  1'b1);
      chk("cin1_ovf4", ovf4, 1'b0);
      ci4 = 1'b0;
      tick();
      chk("cin0_s4",   s4,   4'hF);
      chk("cin0_co4",  co4,  1'b0);
      chk("cin0_vld4", vld4, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
